// File: rtl/cal_uart_tx.sv
// rtl/cal_uart_tx.sv - FIFO-fed UART transmitter, 8N1 or 8E1 when CAL_UART_PARITY_EN is defined
// Frames leave back-to-back while the FIFO holds data; uart_txd is registered and idles high.
module cal_uart_tx #(
    parameter int CLK_SPEED_MHZ = 250,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        uart_txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int CLKS_PER_BIT = (CLK_SPEED_MHZ * 1_000_000 + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int LW           = AW + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(FIFO_DEPTH);

`ifdef CAL_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
`ifdef CAL_UART_PARITY_EN
    logic             r_parity;
`endif

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_txd_nxt;
    logic             w_pop;
    logic             w_push;
    logic             w_bit_done;
    logic             w_fifo_nempty;
    logic [7:0]       w_rd_data;

    assign w_bit_done    = (r_baud_cnt == CNT_LAST);
    assign w_fifo_nempty = (r_level != '0);
    assign w_rd_data     = r_mem[r_rd_ptr];
    assign w_push        = din_valid & din_ready;
    assign din_ready     = (r_level != LVL_FULL);
    assign busy          = (r_state != IDLE) | w_fifo_nempty;
    assign uart_txd      = r_txd;
    assign fifo_level    = r_level;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_done ? '0 : r_baud_cnt + 1'b1;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_txd_nxt = 1'b1;
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_rd_data;
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                end
            end
            DATA: begin
                // The line always shows shift[0], so the next bit is shift[1] before the shift lands.
                if (w_bit_done) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_idx_nxt   = r_bit_idx + 3'd1;
                    w_txd_nxt   = r_shift[1];
                    if (r_bit_idx == 3'd7) begin
`ifdef CAL_UART_PARITY_EN
                        w_state_nxt = PARITY;
                        w_txd_nxt   = r_parity;
`else
                        w_state_nxt = STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end
                end
            end
`ifdef CAL_UART_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_done) begin
                    if (w_fifo_nempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_rd_data;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_cnt_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

`ifdef CAL_UART_PARITY_EN
    // Parity is captured at pop time because the shifter is consumed during DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_rd_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end
endmodule
